fb_axi_rd_slave: RTL and testbench
==================================

// Module: fb_axi_rd_slave
// PURPOSE
//  AXI4 read-only slave serving the LCD frame buffer to lcd_control's M_AXI read master.
//  Holds MEM_WORDS 32-bit words (two RGB565 pixels each) in on-chip RAM.
//  A simple fill port loads the RAM; AXI serves single-outstanding INCR/FIXED bursts.
//  Sits between the frame-buffer loader and the LCD controller's master port.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of word 0
//  MEM_WORDS  9600           RAM depth in 32-bit words (240*80/2)
//  IDX_W      14             word-index width, >= clog2(MEM_WORDS)
// PORTS
//  AXI_ACLK       in   1      clock
//  AXI_ARESETN    in   1      asynchronous, active-low reset
//  S_AXI_ARADDR   in   32     burst start byte address
//  S_AXI_ARLEN    in   8      beats-1
//  S_AXI_ARSIZE   in   3      beat size; only 3'b010 legal
//  S_AXI_ARBURST  in   2      00 FIXED, 01 INCR, 10 WRAP (unsupported)
//  S_AXI_ARVALID  in   1      address valid
//  S_AXI_ARREADY  out  1      address accepted
//  S_AXI_RDATA    out  32     read data
//  S_AXI_RRESP    out  2      00 OKAY, 10 SLVERR
//  S_AXI_RLAST    out  1      final beat of burst
//  S_AXI_RVALID   out  1      data valid
//  S_AXI_RREADY   in   1      master accepts data
//  fill_we        in   1      fill-port write strobe
//  fill_idx       in   IDX_W  fill word index (>= MEM_WORDS ignored)
//  fill_data      in   32     fill word
// BEHAVIOUR
//  Reset: ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0, state IDLE, counters 0.
//  States: IDLE -> (ARVALID&ARREADY) -> BURST -> (RVALID&RREADY&RLAST) -> IDLE.
//  ARREADY=1 only in IDLE; one burst outstanding. ARREADY rises the cycle after the last-beat handshake.
//  On accept: latch idx=(ARADDR-BASE_ADDR)>>2, beats=ARLEN+1, burst, err_burst=(ARSIZE!=010)|(ARBURST==10).
//  RAM is synchronous, 1-cycle read. AR handshake at cycle N -> first RVALID at N+2.
//  No backpressure: one beat per cycle; 20-beat burst => RVALID high N+2..N+21, RLAST at N+21 only.
//  Backpressure: while RVALID & !RREADY, RDATA/RRESP/RLAST hold stable; no RAM advance.
//  INCR: idx+1 per accepted beat; FIXED: idx constant. No wrap modulo MEM_WORDS.
//  Beat with idx >= MEM_WORDS, or err_burst set: RDATA=0, RRESP=10; burst length still honoured.
//  ARADDR[1:0] ignored (aligned). Address below BASE_ADDR wraps to a huge idx -> SLVERR.
//  Fill write and AXI read same idx same cycle: read returns old data (read-first).
//  Fill port is always active, including mid-burst; no effect on AXI handshakes.
//  Reset mid-burst: RVALID drops asynchronously; burst abandoned; RAM contents undefined-retained.
// CONFIGURATION
//  FB_PATTERN_EN defined: RAM and fill port removed (fill_* ignored); data generated as
//   RDATA = {1'b0,idx[13:0],1'b1,1'b0,idx[13:0],1'b0} for idx<MEM_WORDS, same timing/latency.
//  Not defined: RAM-backed behaviour above.
// STRUCTURE
//  Package fb_axi_pkg: RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP, SIZE_4B, state enum {IDLE,BURST}.
//  Sub-module fb_ram_1r1w (IDX_W, MEM_WORDS): 1 write port, 1 sync read-first port with read enable.
//  Top holds AR capture, beat counter, RAM-issue/output-register pipeline with hold logic.
// TESTING
//  Fill idx 0..39 with 32'hA000_0000+idx; AR 0x0,len 19,INCR, RREADY=1 -> 20 beats A000_0000..A000_0013, RLAST beat 20, first RVALID 2 cycles after AR.
//  Same burst, RREADY toggled 1/0 pseudo-random -> identical data sequence, RDATA stable while stalled.
//  AR 0x9588 (idx 9570), len 31 -> beats 0-29 OKAY, beats 30-31 RDATA=0 RRESP=10, RLAST on 32nd.
//  AR ARSIZE=3'b001 len 3 -> 4 beats SLVERR, then ARREADY=1 next cycle; FIXED len 3 at idx 5 -> 4x word 5.
//  Back-to-back ARs held valid -> second accepted cycle after first RLAST handshake, no beat lost/duplicated.
//  Reset asserted mid-burst (beat 7) -> RVALID=0, ARREADY=1 after release, new burst correct.
//  FB_PATTERN_EN build: AR 0x0 len 1 -> RDATA 32'h0001_0000 then 32'h0003_0002.

Source files
------------

// File: rtl/fb_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_axi_pkg
// Brief    : Shared AXI encodings and the FSM state type for the frame-buffer
//            read slave.
// Revision : 1.0  initial release
// ============================================================================
package fb_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // WRAP and the reserved encoding are both served as SLVERR bursts.
    function automatic logic is_err_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst == BURST_WRAP) ||
               ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    function automatic logic [31:0] pattern_word(input logic [13:0] idx);
        return {1'b0, idx, 1'b1, 1'b0, idx, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_axi_rd_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_axi_rd_slave_if
// Brief    : AXI4 read-address and read-data channel bundle with master and
//            slave views.
// Revision : 1.0  initial release
// ============================================================================
interface fb_axi_rd_slave_if;

    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport master (
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

endinterface
`default_nettype wire

// File: rtl/fb_axi_rd_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_ram_1r1w
// Brief    : Frame-buffer word RAM, one write port and one synchronous
//            read-first read port with read enable.
// Revision : 1.0  initial release
// ============================================================================
module fb_ram_1r1w #(
    parameter int IDX_W     = 14,
    parameter int MEM_WORDS = 9600
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [0:MEM_WORDS-1];
    logic [31:0] rdata_q;

    // Read output keeps its value while re_i is low; the top relies on this to hold a stalled beat.
    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < 32'(MEM_WORDS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fb_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : fb_axi_rd_slave
// Brief    : AXI4 read-only slave serving the LCD frame buffer from on-chip
//            RAM; define FB_PATTERN_EN to replace the RAM with a generated
//            index pattern.
// Revision : 1.0  initial release
// ============================================================================
module fb_axi_rd_slave
    import fb_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 9600,
    parameter int          IDX_W     = 14
) (
    input  logic             AXI_ACLK,
    input  logic             AXI_ARESETN,
    fb_axi_rd_slave_if.slave s_axi,
    input  logic             fill_we,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [31:0]      fill_data
);

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_e      state_q;
    logic [29:0] idx_q;
    logic [8:0]  beats_left_q;
    logic        fixed_q;
    logic        err_burst_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic        rerr_q;

    logic [31:0] w_ar_off;
    logic        w_rhs;
    logic        w_issue;
    logic        w_beat_err;
    logic [31:0] w_beat_data;
    logic        unused_ar_lsb;

    assign w_ar_off      = s_axi.S_AXI_ARADDR - BASE_ADDR;
    assign unused_ar_lsb = ^w_ar_off[1:0];
    assign w_rhs         = rvalid_q & s_axi.S_AXI_RREADY;
    assign w_beat_err    = err_burst_q || (idx_q >= MEM_WORDS_W);

    // A beat is issued whenever the output register is empty or being drained this cycle.
    assign w_issue = (state_q == BURST) && (beats_left_q != 9'd0) &&
                     (!rvalid_q || s_axi.S_AXI_RREADY);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            beats_left_q <= '0;
            fixed_q      <= 1'b0;
            err_burst_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rerr_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        idx_q        <= w_ar_off[31:2];
                        beats_left_q <= 9'(s_axi.S_AXI_ARLEN) + 9'd1;
                        fixed_q      <= (s_axi.S_AXI_ARBURST == BURST_FIXED);
                        err_burst_q  <= is_err_burst(s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST);
                        state_q      <= BURST;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        rvalid_q     <= 1'b1;
                        rlast_q      <= (beats_left_q == 9'd1);
                        rerr_q       <= w_beat_err;
                        beats_left_q <= beats_left_q - 9'd1;
                        if (!fixed_q) begin
                            idx_q <= idx_q + 30'd1;
                        end
                    end else if (w_rhs) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                    end
                    if (w_rhs && rlast_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FB_PATTERN_EN
    logic [31:0] pat_q;
    logic        unused_fill;

    assign unused_fill = ^{fill_we, fill_idx, fill_data};

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            pat_q <= '0;
        end else if (w_issue) begin
            pat_q <= pattern_word(idx_q[13:0]);
        end
    end

    assign w_beat_data = pat_q;
`else
    fb_ram_1r1w #(
        .IDX_W     (IDX_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk_i   (AXI_ACLK),
        .we_i    (fill_we),
        .waddr_i (fill_idx),
        .wdata_i (fill_data),
        .re_i    (w_issue && !w_beat_err),
        .raddr_i (idx_q[IDX_W-1:0]),
        .rdata_o (w_beat_data)
    );
`endif

    // The RAM output register is not reset, so data is masked whenever no good beat is presented.
    assign s_axi.S_AXI_RDATA   = (rvalid_q && !rerr_q) ? w_beat_data : 32'd0;
    assign s_axi.S_AXI_RRESP   = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_ARREADY = (state_q == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fb_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_axi_rd_slave
// Brief    : Self-checking bench for fb_axi_rd_slave against a queue-based
//            burst model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_axi_rd_slave;

    localparam int MW = 9600;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rstn;
    logic        fill_we;
    logic [13:0] fill_idx;
    logic [31:0] fill_data;

    fb_axi_rd_slave_if axi();

    fb_axi_rd_slave #(
        .BASE_ADDR (32'h0000_0000),
        .MEM_WORDS (MW),
        .IDX_W     (14)
    ) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rstn),
        .s_axi       (axi),
        .fill_we     (fill_we),
        .fill_idx    (fill_idx),
        .fill_data   (fill_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [MW];
    beat_t       exp_q[$];
    logic [31:0] log_d[$];
    logic [1:0]  log_r[$];
    logic        log_l[$];
    bit          idle = 1'b1;
    int          first_cyc = 0;
    bit          rr_rand = 1'b0;
    bit          fill_rand = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] idx);
`ifdef FB_PATTERN_EN
        logic [31:0] k;
        k = idx & 32'h0000_3FFF;
        return ((2 * k + 1) << 16) | (2 * k);
`else
        return mem[idx];
`endif
    endfunction

    // Model: expected beats of the outstanding burst, computed at the AR handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            chk(axi.S_AXI_RVALID === 1'b0, "rst_rvalid", 32'(axi.S_AXI_RVALID), 0);
            chk(axi.S_AXI_ARREADY === 1'b1, "rst_arready", 32'(axi.S_AXI_ARREADY), 1);
            chk(axi.S_AXI_RLAST === 1'b0, "rst_rlast", 32'(axi.S_AXI_RLAST), 0);
            chk(axi.S_AXI_RRESP === 2'b00, "rst_rresp", 32'(axi.S_AXI_RRESP), 0);
            chk(axi.S_AXI_RDATA === 32'd0, "rst_rdata", axi.S_AXI_RDATA, 0);
            exp_q.delete();
            idle = 1'b1;
        end else begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && (cyc >= first_cyc);
            chk(axi.S_AXI_ARREADY === idle, "arready", 32'(axi.S_AXI_ARREADY), 32'(idle));
            chk(axi.S_AXI_RVALID === exp_v, "rvalid", 32'(axi.S_AXI_RVALID), 32'(exp_v));
            if (axi.S_AXI_RVALID === 1'b1 && exp_q.size() > 0) begin
                chk(axi.S_AXI_RDATA === exp_q[0].d, "rdata", axi.S_AXI_RDATA, exp_q[0].d);
                chk(axi.S_AXI_RRESP === exp_q[0].r, "rresp", 32'(axi.S_AXI_RRESP), 32'(exp_q[0].r));
                chk(axi.S_AXI_RLAST === exp_q[0].l, "rlast", 32'(axi.S_AXI_RLAST), 32'(exp_q[0].l));
                if (axi.S_AXI_RREADY === 1'b1) begin
                    log_d.push_back(axi.S_AXI_RDATA);
                    log_r.push_back(axi.S_AXI_RRESP);
                    log_l.push_back(axi.S_AXI_RLAST);
                    if (exp_q.size() == 1) idle = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            if (axi.S_AXI_ARVALID === 1'b1 && axi.S_AXI_ARREADY === 1'b1) begin
                logic [31:0] base;
                logic [31:0] bi;
                bit          eb;
                int          n;
                beat_t       b;
                base = axi.S_AXI_ARADDR >> 2;
                eb   = (axi.S_AXI_ARSIZE != 3'b010) || (axi.S_AXI_ARBURST == 2'b10);
                n    = int'(axi.S_AXI_ARLEN) + 1;
                for (int i = 0; i < n; i++) begin
                    bi  = (axi.S_AXI_ARBURST == 2'b00) ? base : base + 32'(i);
                    b.l = (i == n - 1);
                    if (eb || bi >= MW) begin
                        b.d = 32'd0;
                        b.r = 2'b10;
                    end else begin
                        b.d = model_word(bi);
                        b.r = 2'b00;
                    end
                    exp_q.push_back(b);
                end
                idle      = 1'b0;
                first_cyc = cyc + 2;
            end
        end
    end

    initial begin
        axi.S_AXI_RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axi.S_AXI_RREADY = rr_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_word(input int idx, input logic [31:0] d);
        fill_we   = 1'b1;
        fill_idx  = 14'(idx);
        fill_data = d;
        if (idx < MW) mem[idx] = d;
        step();
        fill_we = 1'b0;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_r.delete();
        log_l.delete();
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input bit hold);
        bit ok;
        ok = 1'b0;
        axi.S_AXI_ARADDR  = a;
        axi.S_AXI_ARLEN   = len;
        axi.S_AXI_ARSIZE  = sz;
        axi.S_AXI_ARBURST = bt;
        axi.S_AXI_ARVALID = 1'b1;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (axi.S_AXI_ARREADY === 1'b1) ok = 1'b1;
        end
        step();
        if (!ok) chk(1'b0, "ar_timeout", 0, 1);
        if (!hold || !ok) axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        int idx;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (exp_q.size() == 0 && idle) begin
                ok = 1'b1;
                break;
            end
            if (fill_rand && ($urandom % 3 == 0)) begin
                idx       = 5000 + int'($urandom % 100);
                fill_we   = 1'b1;
                fill_idx  = 14'(idx);
                fill_data = $urandom;
                mem[idx]  = fill_data;
            end else begin
                fill_we = 1'b0;
            end
            step();
        end
        fill_we = 1'b0;
        chk(ok, "burst_done", 32'(ok), 1);
    endtask

    initial begin
        rstn              = 1'b0;
        fill_we           = 1'b0;
        fill_idx          = '0;
        fill_data         = '0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARLEN   = '0;
        axi.S_AXI_ARSIZE  = 3'b010;
        axi.S_AXI_ARBURST = 2'b01;
        axi.S_AXI_ARVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();

        for (int i = 0; i < 40; i++) fill_word(i, 32'hA000_0000 + 32'(i));
        for (int i = 40; i < 300; i++) fill_word(i, $urandom);
        for (int i = 9500; i < 9600; i++) fill_word(i, $urandom);
        for (int i = 9570; i < 9600; i++) fill_word(i, 32'hB000_0000 + 32'(i));

`ifdef FB_PATTERN_EN
        clear_log();
        do_ar(32'h0, 8'd1, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 2, "pat_count", 32'(log_d.size()), 2);
        if (log_d.size() == 2) begin
            chk(log_d[0] == 32'h0001_0000, "pat_beat0", log_d[0], 32'h0001_0000);
            chk(log_d[1] == 32'h0003_0002, "pat_beat1", log_d[1], 32'h0003_0002);
        end
`endif

        // 20-beat INCR burst, no backpressure
        clear_log();
        do_ar(32'h0, 8'd19, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 20, "incr_count", 32'(log_d.size()), 20);
        if (log_d.size() == 20) begin
            chk(log_l[19] == 1'b1 && log_l[18] == 1'b0, "incr_last", 32'({log_l[18], log_l[19]}), 1);
`ifndef FB_PATTERN_EN
            chk(log_d[0] == 32'hA000_0000, "incr_first", log_d[0], 32'hA000_0000);
            chk(log_d[19] == 32'hA000_0013, "incr_final", log_d[19], 32'hA000_0013);
`endif
        end

        // same burst under random backpressure
        rr_rand = 1'b1;
        clear_log();
        do_ar(32'h0, 8'd19, 3'b010, 2'b01, 1'b0);
        wait_done();
        rr_rand = 1'b0;
        chk(log_d.size() == 20, "stall_count", 32'(log_d.size()), 20);
`ifndef FB_PATTERN_EN
        if (log_d.size() == 20)
            for (int i = 0; i < 20; i++)
                chk(log_d[i] == 32'hA000_0000 + 32'(i), "stall_data", log_d[i], 32'hA000_0000 + 32'(i));
`endif

        // burst running off the end of the RAM
        clear_log();
        do_ar(32'h0000_9588, 8'd31, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 32, "edge_count", 32'(log_d.size()), 32);
        if (log_d.size() == 32) begin
            chk(log_r[29] == 2'b00, "edge_resp29", 32'(log_r[29]), 0);
            chk(log_r[30] == 2'b10 && log_r[31] == 2'b10, "edge_resp30", 32'({log_r[30], log_r[31]}), 32'hA);
            chk(log_d[30] == 32'd0 && log_d[31] == 32'd0, "edge_data30", log_d[30] | log_d[31], 0);
            chk(log_l[31] == 1'b1, "edge_last", 32'(log_l[31]), 1);
`ifndef FB_PATTERN_EN
            chk(log_d[29] == 32'hB000_0000 + 32'd9599, "edge_data29", log_d[29], 32'hB000_0000 + 32'd9599);
`endif
        end

        // illegal size
        clear_log();
        do_ar(32'h0, 8'd3, 3'b001, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 4, "size_count", 32'(log_d.size()), 4);
        if (log_d.size() == 4)
            chk(log_r[0] == 2'b10 && log_r[3] == 2'b10 && log_d[0] == 0, "size_err", 32'(log_r[0]), 32'h2);

        // FIXED burst at idx 5
        clear_log();
        do_ar(32'h0000_0014, 8'd3, 3'b010, 2'b00, 1'b0);
        wait_done();
        chk(log_d.size() == 4, "fixed_count", 32'(log_d.size()), 4);
`ifndef FB_PATTERN_EN
        if (log_d.size() == 4)
            for (int i = 0; i < 4; i++)
                chk(log_d[i] == 32'hA000_0005, "fixed_data", log_d[i], 32'hA000_0005);
`endif

        // back-to-back with ARVALID held
        clear_log();
        do_ar(32'h0, 8'd4, 3'b010, 2'b01, 1'b1);
        do_ar(32'h0000_0028, 8'd2, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 8, "b2b_count", 32'(log_d.size()), 8);
`ifndef FB_PATTERN_EN
        if (log_d.size() == 8) begin
            chk(log_d[4] == 32'hA000_0004, "b2b_beat4", log_d[4], 32'hA000_0004);
            chk(log_d[5] == 32'hA000_000A, "b2b_beat5", log_d[5], 32'hA000_000A);
        end
`endif

        // fill colliding with the first read of a burst
        clear_log();
        do_ar(32'h0000_000C, 8'd0, 3'b010, 2'b01, 1'b0);
        fill_word(3, 32'h5555_AAAA);
        wait_done();
        do_ar(32'h0000_000C, 8'd0, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 2, "rf_count", 32'(log_d.size()), 2);
`ifndef FB_PATTERN_EN
        if (log_d.size() == 2) begin
            chk(log_d[0] == 32'hA000_0003, "rf_old", log_d[0], 32'hA000_0003);
            chk(log_d[1] == 32'h5555_AAAA, "rf_new", log_d[1], 32'h5555_AAAA);
        end
`endif

        // asynchronous reset during beat 7
        clear_log();
        do_ar(32'h0, 8'd19, 3'b010, 2'b01, 1'b0);
        for (int k = 0; k < 200 && log_d.size() < 7; k++) @(negedge clk);
        chk(log_d.size() >= 7, "mid_reach", 32'(log_d.size()), 7);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk(axi.S_AXI_RVALID === 1'b0, "async_rvalid", 32'(axi.S_AXI_RVALID), 0);
        chk(axi.S_AXI_ARREADY === 1'b1, "async_arready", 32'(axi.S_AXI_ARREADY), 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        clear_log();
        do_ar(32'h0000_0014, 8'd1, 3'b010, 2'b01, 1'b0);
        wait_done();
        chk(log_d.size() == 2, "post_rst_count", 32'(log_d.size()), 2);
`ifndef FB_PATTERN_EN
        if (log_d.size() == 2)
            chk(log_d[1] == 32'hA000_0006, "post_rst_data", log_d[1], 32'hA000_0006);
`endif

        // randomized bursts with live fills elsewhere in the RAM
        rr_rand   = 1'b1;
        fill_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] base;
            logic [31:0] addr;
            logic [7:0]  len;
            logic [2:0]  sz;
            logic [1:0]  bt;
            int          cat;
            int          r;
            bit          hold;
            cat = int'($urandom % 4);
            if (cat < 2)       base = $urandom % 251;
            else if (cat == 2) base = 32'd9560 + ($urandom % 40);
            else               base = 32'h3FFF_FFC0;
            addr = (base << 2) | ($urandom % 4);
            len  = 8'($urandom % 32);
            r    = int'($urandom % 10);
            bt   = (r < 3) ? 2'b00 : (r == 3) ? 2'b10 : 2'b01;
            sz   = ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'b010;
            hold = (i < 39) && ($urandom % 3 == 0);
            do_ar(addr, len, sz, bt, hold);
            if (!hold) begin
                wait_done();
                repeat ($urandom % 3) step();
            end
        end
        rr_rand   = 1'b0;
        fill_rand = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
